// File: rtl/ps2io_pkg.sv
// Shared definitions for the receive-only PS/2 keyboard port: register map,
// STAT/CTRL bit positions and deframer state encoding.
package ps2io_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_LEVL = 2'd3;

  localparam int STAT_AVAIL = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_PERR  = 4;
  localparam int STAT_FERR  = 5;
  localparam int STAT_OVR   = 6;
  localparam int STAT_IRQ   = 7;

  localparam int CTRL_RXIE  = 0;
  localparam int CTRL_ERRIE = 1;
  localparam int CTRL_FLUSH = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2io_rx.sv
// PS/2 receive front end: synchronizers, ps2clk glitch filter, 11-bit deframer
// and in-frame timeout. Emits one-cycle byte/perr/ferr strobes.
module ps2io_rx
  import ps2io_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       perr,
  output logic       ferr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          clk_filt, strobe;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_q;
  rx_state_t     state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      strobe   <= 1'b0;
    end else begin
      {clk_sync, clk_meta} <= {clk_meta, ps2clk};
      {dat_sync, dat_meta} <= {dat_meta, ps2dat};
      strobe <= 1'b0;
      if (clk_sync == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync;
        flt_cnt  <= '0;
        strobe   <= ~clk_sync;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmo_cnt <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE || strobe) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 1'b1;
      if (strobe) begin
        case (state_q)
          ST_IDLE: begin
            bitcnt <= '0;
            shreg  <= '0;
          end
          ST_DATA: begin
            shreg[bitcnt] <= dat_sync;
            bitcnt        <= bitcnt + 1'b1;
          end
          ST_PARITY: par_q <= dat_sync;
          default: ;
        endcase
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_valid = 1'b0;
    perr       = 1'b0;
    ferr       = 1'b0;
    if (state_q != ST_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      ferr    = 1'b1;
      state_d = ST_IDLE;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE:   if (!dat_sync) state_d = ST_DATA;
        ST_DATA:   if (bitcnt == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_sync)                       ferr       = 1'b1;
          else if (odd_parity_ok(shreg, par_q)) byte_valid = 1'b1;
          else                                 perr       = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2io.sv
// PS/2 keyboard port on the 6800 peripheral bus: scan-code FIFO, STAT/CTRL/LEVL
// registers and level interrupt around the ps2io_rx deframer.
module ps2io
  import ps2io_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic       ps2clk,
  input  logic       ps2dat
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          byte_valid, rx_perr, rx_ferr;
  logic [7:0]    rx_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          rxie, errie, perr_f, ferr_f, ovr_f;
  logic          rd, wr, pop_req, stat_rd, flush, empty, full, do_pop, do_push;
  logic [7:0]    stat;
  logic          unused_di;

  ps2io_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .perr      (rx_perr),
    .ferr      (rx_ferr)
  );

  assign rd      = cs & rw;
  assign wr      = cs & ~rw;
  assign pop_req = rd && AD == REG_DATA;
  assign stat_rd = rd && AD == REG_STAT;
  assign flush   = wr && AD == REG_CTRL && DI[CTRL_FLUSH];
  assign empty   = level == '0;
  assign full    = level == LW'(FIFO_DEPTH);
  assign do_pop  = pop_req & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
  assign do_push = byte_valid & (~full | do_pop);
  assign unused_di = ^DI[6:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; level/pointers alone define validity,
  // which keeps the array mappable onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxie   <= 1'b0;
      errie  <= 1'b0;
      perr_f <= 1'b0;
      ferr_f <= 1'b0;
      ovr_f  <= 1'b0;
    end else begin
      if (wr && AD == REG_CTRL) {errie, rxie} <= DI[1:0];
      perr_f <= rx_perr | (perr_f & ~stat_rd);
      ferr_f <= rx_ferr | (ferr_f & ~stat_rd);
      ovr_f  <= (byte_valid & full & ~do_pop) | (ovr_f & ~stat_rd);
    end
  end

  assign irq = (rxie & ~empty) | (errie & (perr_f | ferr_f | ovr_f));

  always_comb begin
    stat             = '0;
    stat[STAT_AVAIL] = ~empty;
    stat[STAT_FULL]  = full;
    stat[STAT_PERR]  = perr_f;
    stat[STAT_FERR]  = ferr_f;
    stat[STAT_OVR]   = ovr_f;
    stat[STAT_IRQ]   = irq;
  end

  always_comb begin
    DO = '0;
    if (rd) begin
      case (AD)
        REG_DATA: DO = empty ? 8'h00 : mem[rptr];
        REG_STAT: DO = stat;
        REG_CTRL: DO = {6'b0, errie, rxie};
        REG_LEVL: DO = 8'(level);
        default:  DO = '0;
      endcase
    end
  end

endmodule
